// File: rtl/npu_load_scheduler.sv
// Job sequencer for one NPU run: streams a weight frame and an activation frame into the
// compute buffers, pulses compute_start, then waits for compute_done.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for job_go; stream stalled
// LOAD_W  | accepting weight words into buffer 0
// LOAD_A  | accepting activation words into buffer 1
// START   | frame set complete; compute_start issued on the next edge
// COMPUTE | waiting for compute_done
module npu_load_scheduler #(
    parameter int C_S_AXIS_TDATA_WIDTH = 8,
    parameter int NUM_WEIGHT_WORDS     = 128,
    parameter int NUM_ACT_WORDS        = 64,
    parameter int ADDR_WIDTH           = 8
) (
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESET,
    input  logic                              job_go,
    input  logic                              reuse_weights,
    input  logic                              S_AXIS_TVALID,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic                              S_AXIS_TLAST,
    output logic                              S_AXIS_TREADY,
    output logic                              buf_wr_en,
    output logic                              buf_wr_sel,
    output logic [ADDR_WIDTH-1:0]             buf_wr_addr,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   buf_wr_data,
    output logic                              compute_start,
    input  logic                              compute_done,
    output logic                              busy,
    output logic                              weights_valid,
    output logic                              frame_err,
    output logic [15:0]                       jobs_done
);

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_A, START, COMPUTE} state_t;

    localparam logic [ADDR_WIDTH-1:0] W_LAST = ADDR_WIDTH'(NUM_WEIGHT_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] A_LAST = ADDR_WIDTH'(NUM_ACT_WORDS - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] word_cnt;
    logic                  handshake;
    logic                  at_last;
    logic                  unused_strb;

    assign handshake   = S_AXIS_TVALID && S_AXIS_TREADY;
    assign at_last     = (state == LOAD_A) ? (word_cnt == A_LAST) : (word_cnt == W_LAST);
    assign unused_strb = ^S_AXIS_TSTRB;

    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            state         <= IDLE;
            word_cnt      <= '0;
            S_AXIS_TREADY <= 1'b0;
            buf_wr_en     <= 1'b0;
            buf_wr_sel    <= 1'b0;
            buf_wr_addr   <= '0;
            buf_wr_data   <= '0;
            compute_start <= 1'b0;
            busy          <= 1'b0;
            weights_valid <= 1'b0;
            frame_err     <= 1'b0;
            jobs_done     <= 16'd0;
        end else begin
            buf_wr_en     <= 1'b0;
            compute_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (job_go) begin
                        frame_err     <= 1'b0;
                        word_cnt      <= '0;
                        S_AXIS_TREADY <= 1'b1;
                        busy          <= 1'b1;
                        if (reuse_weights && weights_valid) begin
                            state <= LOAD_A;
                        end else begin
                            weights_valid <= 1'b0;
                            state         <= LOAD_W;
                        end
                    end
                end
                LOAD_W, LOAD_A: begin
                    if (handshake) begin
                        // The word is written even when it turns out to break framing.
                        buf_wr_en   <= 1'b1;
                        buf_wr_sel  <= (state == LOAD_A);
                        buf_wr_addr <= word_cnt;
                        buf_wr_data <= S_AXIS_TDATA;
                        word_cnt    <= word_cnt + 1'b1;
                        if (S_AXIS_TLAST != at_last) begin
                            frame_err     <= 1'b1;
                            S_AXIS_TREADY <= 1'b0;
                            busy          <= 1'b0;
                            state         <= IDLE;
                        end else if (at_last) begin
                            if (state == LOAD_W) begin
                                weights_valid <= 1'b1;
                                word_cnt      <= '0;
                                state         <= LOAD_A;
                            end else begin
                                S_AXIS_TREADY <= 1'b0;
                                state         <= START;
                            end
                        end
                    end
                end
                START: begin
                    compute_start <= 1'b1;
                    state         <= COMPUTE;
                end
                COMPUTE: begin
                    if (compute_done) begin
                        jobs_done <= jobs_done + 16'd1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    S_AXIS_TREADY <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule
